// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: two-port register-file writeback arbiter with B starvation guard and write forwarding
module rf_wb_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        RegWrite,
  output logic [4:0]  WriteReg,
  output logic [31:0] WriteData,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  output logic [31:0] FwdData1,
  output logic [31:0] FwdData2,
  output logic        b_starved
);
  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_starved;
  logic          r_wr;
  logic [4:0]    r_rd;
  logic [31:0]   r_data;
  logic          w_acc;
  logic [4:0]    w_rd;
  logic [31:0]   w_data;
  // A wins by default; B wins when alone or once it has been stalled STARVE_LIMIT cycles
  always_comb begin
    a_ready   = rst && a_valid && !(b_valid && r_starved);
    b_ready   = rst && b_valid && (!a_valid || r_starved);
    w_acc     = a_ready || b_ready;
    w_rd      = b_ready ? b_rd : a_rd;
    w_data    = b_ready ? b_data : a_data;
    w_cnt_nxt = (b_valid && !b_ready) ? ((r_cnt == LIM) ? r_cnt : r_cnt + CW'(1)) : '0;
  end
  // in-flight write bypasses the register file read; x0 always reads as zero
  always_comb begin
    FwdData1 = (rs1 == 5'd0) ? '0 : (r_wr && r_rd == rs1) ? r_data : ReadData1;
    FwdData2 = (rs2 == 5'd0) ? '0 : (r_wr && r_rd == rs2) ? r_data : ReadData2;
  end
  // launch register and starvation counter; starved flag is precomputed so it aligns with the forced grant
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr      <= 1'b0;
      r_rd      <= '0;
      r_data    <= '0;
      r_cnt     <= '0;
      r_starved <= 1'b0;
    end else begin
      r_wr      <= w_acc && (w_rd != 5'd0);
      r_rd      <= w_rd;
      r_data    <= w_data;
      r_cnt     <= w_cnt_nxt;
      r_starved <= (w_cnt_nxt == LIM);
    end
  end
  assign RegWrite  = r_wr;
  assign WriteReg  = r_rd;
  assign WriteData = r_data;
  assign b_starved = r_starved;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed scenarios plus randomized traffic against a cycle-level reference model
module tb_rf_wb_arbiter;
  localparam int LIM = 3;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [4:0]  a_rd = '0, b_rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] a_data = '0, b_data = '0, ReadData1 = '0, ReadData2 = '0;
  logic        a_ready, b_ready, RegWrite, b_starved;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData, FwdData1, FwdData2;
  int n_chk = 0;
  int n_fail = 0;

  rf_wb_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .rs1(rs1), .rs2(rs2), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .FwdData1(FwdData1), .FwdData2(FwdData2), .b_starved(b_starved)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; a_valid = 1'b1; b_valid = 1'b1; a_rd = 5'd4; b_rd = 5'd6;
    #1;
    n_chk++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL reset_a_ready got %0b want 0", a_ready); end
    n_chk++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL reset_b_ready got %0b want 0", b_ready); end
    @(posedge clk); #1;
    n_chk++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite got %0b want 0", RegWrite); end
    n_chk++; if (WriteReg !== 5'd0) begin n_fail++; $display("FAIL reset_writereg got %0d want 0", WriteReg); end
    n_chk++; if (WriteData !== 32'd0) begin n_fail++; $display("FAIL reset_writedata got %h want 0", WriteData); end
    n_chk++; if (b_starved !== 1'b0) begin n_fail++; $display("FAIL reset_starved got %0b want 0", b_starved); end
  endtask

  task automatic test_single_a();
    @(negedge clk);
    rst = 1'b1; b_valid = 1'b0; a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h1234;
    #1;
    n_chk++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL single_a_ready got %0b want 1", a_ready); end
    n_chk++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL single_b_ready got %0b want 0", b_ready); end
    @(posedge clk); #1;
    n_chk++; if (RegWrite !== 1'b1) begin n_fail++; $display("FAIL single_regwrite got %0b want 1", RegWrite); end
    n_chk++; if (WriteReg !== 5'd5) begin n_fail++; $display("FAIL single_writereg got %0d want 5", WriteReg); end
    n_chk++; if (WriteData !== 32'h0000_1234) begin n_fail++; $display("FAIL single_writedata got %h want 00001234", WriteData); end
    @(negedge clk);
    a_valid = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL single_regwrite_drop got %0b want 0", RegWrite); end
  endtask

  task automatic test_starvation();
    @(negedge clk);
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'hA0A0;
    b_valid = 1'b1; b_rd = 5'd9; b_data = 32'hB0B0;
    for (int k = 0; k <= LIM + 1; k++) begin
      #1;
      n_chk++; if (a_ready !== (k != LIM)) begin n_fail++; $display("FAIL starve_a_ready[%0d] got %0b want %0b", k, a_ready, k != LIM); end
      n_chk++; if (b_ready !== (k == LIM)) begin n_fail++; $display("FAIL starve_b_ready[%0d] got %0b want %0b", k, b_ready, k == LIM); end
      n_chk++; if (b_starved !== (k == LIM)) begin n_fail++; $display("FAIL starve_flag[%0d] got %0b want %0b", k, b_starved, k == LIM); end
      @(posedge clk); #1;
      n_chk++; if (WriteReg !== ((k == LIM) ? 5'd9 : 5'd3)) begin n_fail++; $display("FAIL starve_writereg[%0d] got %0d want %0d", k, WriteReg, (k == LIM) ? 9 : 3); end
      @(negedge clk);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_rd_zero();
    @(negedge clk);
    b_valid = 1'b1; b_rd = 5'd0; b_data = 32'hFFFF_FFFF;
    #1;
    n_chk++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_b_ready got %0b want 1", b_ready); end
    @(posedge clk); #1;
    n_chk++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL rd0_regwrite got %0b want 0", RegWrite); end
    @(negedge clk);
    b_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_forward();
    @(negedge clk);
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'hAA;
    @(posedge clk); #1;
    rs1 = 5'd7; rs2 = 5'd8; ReadData1 = 32'h11; ReadData2 = 32'h22;
    #1;
    n_chk++; if (FwdData1 !== 32'hAA) begin n_fail++; $display("FAIL fwd1_hit got %h want aa", FwdData1); end
    n_chk++; if (FwdData2 !== 32'h22) begin n_fail++; $display("FAIL fwd2_miss got %h want 22", FwdData2); end
    rs1 = 5'd0; rs2 = 5'd7;
    #1;
    n_chk++; if (FwdData1 !== 32'h0) begin n_fail++; $display("FAIL fwd1_x0 got %h want 0", FwdData1); end
    n_chk++; if (FwdData2 !== 32'hAA) begin n_fail++; $display("FAIL fwd2_hit got %h want aa", FwdData2); end
    @(negedge clk);
    a_valid = 1'b0;
    @(posedge clk); #1;
    rs2 = 5'd7;
    #1;
    n_chk++; if (FwdData2 !== 32'h22) begin n_fail++; $display("FAIL fwd2_stale got %h want 22", FwdData2); end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    a_valid = 1'b1; a_rd = 5'd12; a_data = 32'hC0DE;
    @(posedge clk); #1;
    n_chk++; if (RegWrite !== 1'b1) begin n_fail++; $display("FAIL mid_regwrite_pre got %0b want 1", RegWrite); end
    @(negedge clk);
    rst = 1'b0; b_valid = 1'b1; b_rd = 5'd13;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_chk++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL mid_a_ready[%0d] got %0b want 0", k, a_ready); end
      n_chk++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL mid_b_ready[%0d] got %0b want 0", k, b_ready); end
      @(posedge clk); #1;
      n_chk++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL mid_regwrite[%0d] got %0b want 0", k, RegWrite); end
      @(negedge clk);
    end
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int s = 0;
    bit ew = 0;
    logic [4:0] erd = '0;
    logic [31:0] ed = '0, e1, e2;
    bit er, ga, gb, la = 0, lb = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      er = ($urandom_range(0, 24) != 0);
      rst = er;
      if (!a_valid || la) begin a_valid = ($urandom_range(0, 2) != 0); a_rd = 5'($urandom); a_data = $urandom; end
      if (!b_valid || lb) begin b_valid = ($urandom_range(0, 2) != 0); b_rd = 5'($urandom); b_data = $urandom; end
      rs1 = ($urandom_range(0, 1) != 0) ? erd : 5'($urandom);
      rs2 = ($urandom_range(0, 1) != 0) ? erd : 5'($urandom);
      ReadData1 = $urandom; ReadData2 = $urandom;
      #1;
      ga = er && a_valid && !(b_valid && s == LIM);
      gb = er && b_valid && (!a_valid || s == LIM);
      e1 = (rs1 == 0) ? 32'd0 : (ew && erd == rs1) ? ed : ReadData1;
      e2 = (rs2 == 0) ? 32'd0 : (ew && erd == rs2) ? ed : ReadData2;
      n_chk++; if (a_ready !== ga) begin n_fail++; $display("FAIL rnd_a_ready[%0d] got %0b want %0b", i, a_ready, ga); end
      n_chk++; if (b_ready !== gb) begin n_fail++; $display("FAIL rnd_b_ready[%0d] got %0b want %0b", i, b_ready, gb); end
      n_chk++; if (b_starved !== (s == LIM)) begin n_fail++; $display("FAIL rnd_starved[%0d] got %0b want %0b", i, b_starved, s == LIM); end
      n_chk++; if (FwdData1 !== e1) begin n_fail++; $display("FAIL rnd_fwd1[%0d] got %h want %h", i, FwdData1, e1); end
      n_chk++; if (FwdData2 !== e2) begin n_fail++; $display("FAIL rnd_fwd2[%0d] got %h want %h", i, FwdData2, e2); end
      @(posedge clk);
      if (!er) begin
        ew = 0; s = 0;
      end else begin
        ew = (ga && a_rd != 0) || (gb && b_rd != 0);
        if (ga) begin erd = a_rd; ed = a_data; end
        if (gb) begin erd = b_rd; ed = b_data; end
        s = (b_valid && !gb) ? ((s < LIM) ? s + 1 : LIM) : 0;
      end
      la = ga; lb = gb;
      #1;
      n_chk++; if (RegWrite !== ew) begin n_fail++; $display("FAIL rnd_regwrite[%0d] got %0b want %0b", i, RegWrite, ew); end
      if (ew) begin
        n_chk++; if (WriteReg !== erd) begin n_fail++; $display("FAIL rnd_writereg[%0d] got %0d want %0d", i, WriteReg, erd); end
        n_chk++; if (WriteData !== ed) begin n_fail++; $display("FAIL rnd_writedata[%0d] got %h want %h", i, WriteData, ed); end
      end
    end
    @(negedge clk);
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_starvation();
    test_rd_zero();
    test_forward();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
